// File: rtl/phase_sequencer.sv
// Run/step/halt phase controller for the multi-cycle core: debounces exec,
// emits phase 0..5, stops cleanly at instruction boundaries.
//
// Ports:
//   clk, rst (async, active-low)
//   exec        raw button, active-low, asynchronous
//   step_mode   1 = one instruction per press
//   hlt         halt indication from the control unit
//   phase       0 = stopped, 1..5 = instruction phase
//   executing   phase is 1..5
//   halted      a halt instruction retired, until next press
//   instr_count retired instruction count (wraps)
//   press_evt   one-cycle pulse per accepted press
module phase_sequencer #(
  parameter logic [15:0] DEBOUNCE_CYCLES = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        exec,
  input  logic        step_mode,
  input  logic        hlt,
  output logic [2:0]  phase,
  output logic        executing,
  output logic        halted,
  output logic [15:0] instr_count,
  output logic        press_evt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  localparam logic [15:0] DB_LAST =
    DEBOUNCE_CYCLES - 16'd1;

  logic        s1_q, s2_q;
  logic        db_q, db_prev_q;
  logic        press_q;
  logic [15:0] db_cnt_q;

  state_t      state_q, state_d;
  logic [2:0]  phase_q, phase_d;
  logic [15:0] icnt_q, icnt_d;
  logic        hlt_lat_q, hlt_lat_d;
  logic        stop_q, stop_d;

  // db_prev_q delays the debounced level so the
  // press pulse lands one cycle after the fall.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_q      <= 1'b1;
      s2_q      <= 1'b1;
      db_q      <= 1'b1;
      db_prev_q <= 1'b1;
      press_q   <= 1'b0;
      db_cnt_q  <= '0;
    end else begin
      s1_q      <= exec;
      s2_q      <= s1_q;
      db_prev_q <= db_q;
      press_q   <= db_prev_q & ~db_q;
      if (s2_q == db_q) begin
        db_cnt_q <= '0;
      end else if (db_cnt_q == DB_LAST) begin
        db_q     <= s2_q;
        db_cnt_q <= '0;
      end else begin
        db_cnt_q <= db_cnt_q + 16'd1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      phase_q   <= 3'd0;
      icnt_q    <= '0;
      hlt_lat_q <= 1'b0;
      stop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      icnt_q    <= icnt_d;
      hlt_lat_q <= hlt_lat_d;
      stop_q    <= stop_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    icnt_d    = icnt_q;
    hlt_lat_d = hlt_lat_q;
    stop_d    = stop_q;
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (press_q) begin
          state_d   = S_RUN;
          phase_d   = 3'd1;
          hlt_lat_d = 1'b0;
          stop_d    = 1'b0;
        end
      end
      S_RUN: begin
        hlt_lat_d = hlt_lat_q | hlt;
        stop_d    = stop_q | press_q;
        if (phase_q != 3'd5) begin
          phase_d = phase_q + 3'd1;
        end else begin
          icnt_d = icnt_q + 16'd1;
          // A press seen here while halting or
          // stepping is absorbed, not a restart.
          if (hlt_lat_q | hlt) begin
            state_d = S_HALT;
            phase_d = 3'd0;
          end else if (stop_q | press_q | step_mode) begin
            state_d = S_IDLE;
            phase_d = 3'd0;
          end else begin
            phase_d   = 3'd1;
            hlt_lat_d = 1'b0;
            stop_d    = 1'b0;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        phase_d = 3'd0;
      end
    endcase
  end

  always_comb begin
    phase       = phase_q;
    executing   = (state_q == S_RUN);
    halted      = (state_q == S_HALT);
    instr_count = icnt_q;
    press_evt   = press_q;
  end

endmodule
